// File: rtl/avr_uart_loader_if.sv
// Memory-side bus of the UART loader: byte-wide reads and writes on a 16-bit address.
// The loader is the master; RAM (or a bench model) is the slave and returns mem_rd one cycle after mem_re.
interface avr_uart_loader_if;
  logic [15:0] mem_a;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  modport master (
    output mem_a,
    output mem_we,
    output mem_re,
    output mem_wd,
    input  mem_rd
  );

  modport slave (
    input  mem_a,
    input  mem_we,
    input  mem_re,
    input  mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/avr_uart_loader.sv
// Host-facing UART bridge: parses W/R/C command frames from rxd, drives the RAM port and cpu_rst,
// and answers each command with a single reply byte on txd.
module avr_uart_loader #(
  parameter logic [7:0] PRESCALER = 8'd12,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              txd,
  output logic              cpu_rst,
  output logic              busy,
  avr_uart_loader_if.master mem
);

  localparam logic [10:0] BIT_LAST = 11'(8 * (int'(PRESCALER) + 1) - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, MEM, REPLY} state_t;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_CTRL} op_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t   rx_state, rx_next;
  logic        rxd_q;
  logic [7:0]  rx_pre;
  logic [2:0]  rx_sub;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_tick, rx_sample, rx_strobe, rx_ferr;

  state_t      state, next;
  op_t         op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  reply;
  logic        rd_pend;
  logic        waiting;
  logic        we, re, tx_load;

  logic [10:0] tmo_div;
  logic [8:0]  tmo_cnt;
  logic        tmo_run, tmo_expired;

  tx_state_t   tx_state, tx_next;
  logic [7:0]  tx_pre;
  logic [2:0]  tx_sub;
  logic [3:0]  tx_cnt;
  logic [8:0]  tx_shift;
  logic        tx_tick, tx_bit_end;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rxd_q && !rxd) rx_next = RX_START;
      RX_START: if (rx_sample) rx_next = rxd ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && rx_bits == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_sample) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Samples land on every 8th sub-tick, offset by 4 so they fall mid-bit.
  always_comb begin
    rx_tick   = (rx_pre == PRESCALER);
    rx_sample = rx_tick && (rx_sub == 3'd3);
    rx_strobe = (rx_state == RX_STOP) && rx_sample && rxd;
    rx_ferr   = (rx_state == RX_STOP) && rx_sample && !rxd;
  end

  // rxd_q follows rxd even in reset so an edge coinciding with rst is never seen.
  always_ff @(posedge clk) begin
    rxd_q <= rxd;
    if (rst || rx_state == RX_IDLE) begin
      rx_pre  <= 8'd0;
      rx_sub  <= 3'd0;
      rx_bits <= 3'd0;
    end else begin
      rx_pre <= rx_tick ? 8'd0 : rx_pre + 8'd1;
      if (rx_tick) rx_sub <= rx_sub + 3'd1;
      if (rx_sample && rx_state == RX_DATA) begin
        rx_shift <= {rxd, rx_shift[7:1]};
        rx_bits  <= rx_bits + 3'd1;
      end
    end
  end

  // Inter-byte timer only counts idle line time, so a byte in flight never trips it.
  always_comb begin
    waiting     = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
    tmo_run     = waiting && (rx_state == RX_IDLE);
    tmo_expired = (tmo_cnt > {1'b0, TIMEOUT});
  end

  always_ff @(posedge clk) begin
    if (rst || !tmo_run) begin
      tmo_div <= 11'd0;
      tmo_cnt <= 9'd0;
    end else if (tmo_div == BIT_LAST) begin
      tmo_div <= 11'd0;
      tmo_cnt <= tmo_cnt + 9'd1;
    end else begin
      tmo_div <= tmo_div + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:
        if (rx_strobe) begin
          case (rx_shift)
            8'h57, 8'h52: next = ADDR_HI;
            8'h43:        next = DATA;
            default:      next = REPLY;
          endcase
        end
      ADDR_HI: if (rx_strobe) next = ADDR_LO;
      ADDR_LO: if (rx_strobe) next = (op == OP_WRITE) ? DATA : MEM;
      DATA:    if (rx_strobe) next = (op == OP_WRITE) ? MEM : REPLY;
      MEM:     if (op == OP_WRITE || rd_pend) next = REPLY;
      REPLY:   if (tx_state == TX_IDLE) next = IDLE;
      default: next = IDLE;
    endcase
    if (waiting && (rx_ferr || tmo_expired)) next = IDLE;
  end

  always_comb begin
    busy    = (state != IDLE);
    we      = (state == MEM) && (op == OP_WRITE);
    re      = (state == MEM) && (op == OP_READ) && !rd_pend;
    tx_load = (state == REPLY) && (tx_state == TX_IDLE);
  end

  // A read spends two cycles in MEM: strobe first, then capture mem_rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= OP_WRITE;
      addr    <= 16'd0;
      wdata   <= 8'd0;
      cpu_rst <= 1'b0;
      reply   <= 8'd0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= 1'b0;
      case (state)
        IDLE:
          if (rx_strobe) begin
            case (rx_shift)
              8'h57:   op    <= OP_WRITE;
              8'h52:   op    <= OP_READ;
              8'h43:   op    <= OP_CTRL;
              default: reply <= 8'h3F;
            endcase
          end
        ADDR_HI: if (rx_strobe) addr[15:8] <= rx_shift;
        ADDR_LO: if (rx_strobe) addr[7:0] <= rx_shift;
        DATA:
          if (rx_strobe) begin
            if (op == OP_WRITE) begin
              wdata <= rx_shift;
            end else begin
              cpu_rst <= rx_shift[0];
              reply   <= 8'h2E;
            end
          end
        MEM:
          if (op == OP_WRITE) reply <= 8'h2E;
          else if (rd_pend)   reply <= mem.mem_rd;
          else                rd_pend <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.mem_a  = addr;
  assign mem.mem_wd = wdata;
  assign mem.mem_we = we;
  assign mem.mem_re = re;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_load) tx_next = TX_SEND;
      TX_SEND: if (tx_bit_end && tx_cnt == 4'd9) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_tick    = (tx_pre == PRESCALER);
    tx_bit_end = tx_tick && (tx_sub == 3'd7);
  end

  // tx_shift carries data then the stop bit; ones shift in behind so the line rests high.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd      <= 1'b1;
      tx_pre   <= 8'd0;
      tx_sub   <= 3'd0;
      tx_cnt   <= 4'd0;
      tx_shift <= 9'h1FF;
    end else if (tx_load) begin
      txd      <= 1'b0;
      tx_shift <= {1'b1, reply};
      tx_pre   <= 8'd0;
      tx_sub   <= 3'd0;
      tx_cnt   <= 4'd0;
    end else if (tx_state == TX_SEND) begin
      tx_pre <= tx_tick ? 8'd0 : tx_pre + 8'd1;
      if (tx_tick) tx_sub <= tx_sub + 3'd1;
      if (tx_bit_end) begin
        txd      <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_cnt   <= tx_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_avr_uart_loader.sv
// Scoreboard bench for avr_uart_loader: stimulus pushes expected replies and memory accesses,
// independent monitors decode txd and watch the memory strobes.
module tb_avr_uart_loader;

  localparam int Q   = 4;
  localparam int BIT = 8 * Q;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } mem_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic txd, cpu_rst, busy;

  avr_uart_loader_if mem_bus ();

  avr_uart_loader #(
    .PRESCALER(8'd3),
    .TIMEOUT  (8'd4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .txd    (txd),
    .cpu_rst(cpu_rst),
    .busy   (busy),
    .mem    (mem_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_stop_cyc = 0;
  int tx_fall_cyc = 0;
  int tx_fall_cnt = 0;
  int tx_fall_ref = 0;
  bit tx_skip = 1'b0;

  logic [7:0] exp_tx[$];
  mem_ev_t    exp_mem[$];

  logic        pre_en = 1'b0;
  logic [15:0] pre_a = 16'd0;
  logic [7:0]  pre_d = 8'd0;
  logic [7:0]  ram [0:65535];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, preload port for the bench.
  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else if (mem_bus.mem_we === 1'b1) ram[mem_bus.mem_a] <= mem_bus.mem_wd;
    if (mem_bus.mem_re === 1'b1) mem_bus.mem_rd <= ram[mem_bus.mem_a];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_max(input string name, input int act, input int lim);
    checks++;
    if (act < 1 || act > lim) begin
      failures++;
      $display("[TB] FAIL %s: got %0d cycles expected 1..%0d", name, act, lim);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    last_stop_cyc = cyc + 76 * Q;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic apply_stimulus(input int n, input logic [31:0] bytes);
    tx_fall_ref = tx_fall_cnt;
    for (int i = 0; i < n; i++) send_byte(bytes[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic wait_reply(input string name, input int lim);
    int n = 0;
    while (tx_fall_cnt == tx_fall_ref && n < 2 * BIT) begin
      @(negedge clk);
      n++;
    end
    if (tx_fall_cnt == tx_fall_ref) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no reply expected a start bit", name);
    end else begin
      check_max(name, tx_fall_cyc - last_stop_cyc, lim);
    end
    repeat (11 * BIT) @(negedge clk);
  endtask

  // TX monitor: decodes each frame at mid-bit and pops the scoreboard.
  initial begin
    logic [7:0] b;
    logic       stop_v;
    b = 8'd0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && rst === 1'b0) begin
        tx_fall_cyc = cyc;
        tx_fall_cnt++;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        stop_v = txd;
        if (tx_skip) begin
          tx_skip = 1'b0;
        end else if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL tx_unexpected: got %0h expected none", b);
        end else begin
          check_output("tx_byte", {23'd0, stop_v, b}, {23'd0, 1'b1, exp_tx.pop_front()});
        end
      end
    end
  end

  // Memory monitor: every strobe must match the next expected access.
  initial begin
    mem_ev_t e;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_we === 1'b1 || mem_bus.mem_re === 1'b1) begin
        if (mem_bus.mem_we === 1'b1 && mem_bus.mem_re === 1'b1) begin
          checks++;
          failures++;
          $display("[TB] FAIL strobe_overlap: got we=1 re=1 expected one strobe");
        end
        if (exp_mem.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL mem_unexpected: got we=%0b a=%0h expected none",
                   mem_bus.mem_we, mem_bus.mem_a);
        end else begin
          e = exp_mem.pop_front();
          check_output("mem_access",
                       {7'd0, mem_bus.mem_we, mem_bus.mem_a, (mem_bus.mem_we ? mem_bus.mem_wd : 8'h00)},
                       {7'd0, e});
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no end of test expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_output("reset_txd", txd, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_cpu_rst", cpu_rst, 0);
    check_output("reset_mem_we", mem_bus.mem_we, 0);
    check_output("reset_mem_re", mem_bus.mem_re, 0);
    check_output("reset_mem_a", mem_bus.mem_a, 0);
    check_output("reset_mem_wd", mem_bus.mem_wd, 0);

    pre_en = 1'b1; pre_a = 16'hBEEF; pre_d = 8'h3C;
    @(negedge clk);
    pre_a = 16'h0000; pre_d = 8'h5A;
    @(negedge clk);
    pre_en = 1'b0;

    $display("[TB] write frame");
    exp_mem.push_back({1'b1, 16'h1234, 8'hA5});
    exp_tx.push_back(8'h2E);
    apply_stimulus(4, 32'h571234A5);
    wait_reply("write_latency", 4);

    exp_mem.push_back({1'b0, 16'h1234, 8'h00});
    exp_tx.push_back(8'hA5);
    apply_stimulus(3, 32'h00521234);
    wait_reply("readback_latency", 5);

    $display("[TB] read frame");
    exp_mem.push_back({1'b0, 16'hBEEF, 8'h00});
    exp_tx.push_back(8'h3C);
    apply_stimulus(3, 32'h0052BEEF);
    wait_reply("read_latency", 5);

    $display("[TB] control and unknown");
    exp_tx.push_back(8'h2E);
    apply_stimulus(2, 32'h00004301);
    wait_reply("ctrl_set_latency", 4);
    check_output("cpu_rst_set", cpu_rst, 1);

    exp_tx.push_back(8'h2E);
    apply_stimulus(2, 32'h00004300);
    wait_reply("ctrl_clr_latency", 4);
    check_output("cpu_rst_clr", cpu_rst, 0);

    exp_tx.push_back(8'h3F);
    apply_stimulus(1, 32'h00000099);
    wait_reply("unknown_latency", 4);

    $display("[TB] framing error and glitch");
    send_byte(8'h57, 1'b1);
    check_output("frame_busy_mid", busy, 1);
    send_byte(8'h12, 1'b0);
    @(negedge clk);
    check_output("frame_busy_dropped", busy, 0);
    repeat (12 * BIT) @(negedge clk);
    exp_mem.push_back({1'b0, 16'h0000, 8'h00});
    exp_tx.push_back(8'h5A);
    apply_stimulus(3, 32'h00520000);
    wait_reply("after_frame_latency", 5);

    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check_output("glitch_busy", busy, 0);

    $display("[TB] timeout");
    apply_stimulus(2, 32'h00005700);
    check_output("timeout_busy_mid", busy, 1);
    repeat (6 * BIT) @(negedge clk);
    check_output("timeout_busy_idle", busy, 0);
    exp_mem.push_back({1'b0, 16'h0000, 8'h00});
    exp_tx.push_back(8'h5A);
    apply_stimulus(3, 32'h00520000);
    wait_reply("after_timeout_latency", 5);

    $display("[TB] reset during reply");
    tx_skip = 1'b1;
    apply_stimulus(2, 32'h00004301);
    if (tx_fall_cnt == tx_fall_ref) begin
      checks++;
      failures++;
      $display("[TB] FAIL reset_reply_start: got no reply expected a start bit");
    end else begin
      d = tx_fall_cyc + 4 * BIT + BIT / 2 - cyc;
      if (d > 0) repeat (d) @(negedge clk);
    end
    check_output("cpu_rst_before_reset", cpu_rst, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_txd", txd, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_cpu_rst", cpu_rst, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    check_output("rst_txd_stays_idle", txd, 1);
    repeat (10 * BIT) @(negedge clk);

    exp_mem.push_back({1'b0, 16'hBEEF, 8'h00});
    exp_tx.push_back(8'h3C);
    apply_stimulus(3, 32'h0052BEEF);
    wait_reply("after_reset_latency", 5);

    check_output("tx_queue_empty", exp_tx.size(), 0);
    check_output("mem_queue_empty", exp_mem.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
